// File: rtl/btn_debounce_selector_if.sv
// Operation-mode type shared by the selector front end and its consumers,
// plus the button/selection bundle connecting the raw buttons to the selector.

package types_pkg;
  typedef enum logic [2:0] {
    RESET        = 3'd0,
    ADD          = 3'd1,
    SUB          = 3'd2,
    MUL          = 3'd3,
    LEADING_ONES = 3'd4,
    COUNT_ONES   = 3'd5
  } opr_mode_t;
endpackage

interface btn_debounce_selector_if;
  import types_pkg::*;

  // Raw push-buttons, asynchronous to the system clock
  logic      BTNC;
  logic      BTNU;
  logic      BTND;
  logic      BTNL;
  logic      BTNR;
  // Sticky selection and its load pulse, debounced button levels {C,U,D,L,R}
  opr_mode_t SELECTOR;
  logic      SEL_STROBE;
  logic [4:0] BTN_DB;

  // Button side: drives the buttons and observes the selection
  modport master (
    output BTNC, BTNU, BTND, BTNL, BTNR,
    input  SELECTOR, SEL_STROBE, BTN_DB
  );

  // Selector side: consumes the buttons and produces the selection
  modport slave (
    input  BTNC, BTNU, BTND, BTNL, BTNR,
    output SELECTOR, SEL_STROBE, BTN_DB
  );
endinterface

// File: rtl/btn_debounce_selector.sv
// Button front end for the operation selector: per-button 2-FF synchroniser
// and counter debounce, press-edge detection, and a sticky priority-encoded
// operation-mode register with a one-cycle load strobe.

module btn_debounce_selector
  import types_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic                    CLK100MHZ,
  input  logic                    CPU_RESETN,
  btn_debounce_selector_if.slave  bus
);

  // A one-bit counter is the floor so DB_CYCLES = 2 still gets a real counter
  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  // Bit 4 is BTNC, bit 0 is BTNR; bit order doubles as press priority
  logic [4:0] raw;
  logic [4:0] db;
  logic [4:0] db_q;
  logic [4:0] press;

  assign raw = {bus.BTNC, bus.BTNU, bus.BTND, bus.BTNL, bus.BTNR};

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_btn
      logic          sync1;
      logic          sync2;
      logic          level;
      logic [CW-1:0] cnt;

      // Two-stage synchroniser for the asynchronous button input
      always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
          sync1 <= 1'b0;
          sync2 <= 1'b0;
        end else begin
          sync1 <= raw[gi];
          sync2 <= sync1;
        end
      end

      // Accept a new level only after it has been stable for the full window;
      // any return to the current level restarts the window
      always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
          level <= 1'b0;
          cnt   <= '0;
        end else if (sync2 == level) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign db[gi] = level;
    end
  endgenerate

  // One-cycle-delayed debounced levels for rising-edge (press) detection
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      db_q <= '0;
    end else begin
      db_q <= db;
    end
  end

  // Releases are deliberately ignored; only a press changes the selection
  assign press = db & ~db_q;

  // Load the highest-priority pressed mode and pulse the strobe; otherwise hold
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      bus.SELECTOR   <= RESET;
      bus.SEL_STROBE <= 1'b0;
    end else begin
      bus.SEL_STROBE <= |press;
      if (press[4]) begin
        bus.SELECTOR <= MUL;
      end else if (press[3]) begin
        bus.SELECTOR <= LEADING_ONES;
      end else if (press[2]) begin
        bus.SELECTOR <= COUNT_ONES;
      end else if (press[1]) begin
        bus.SELECTOR <= ADD;
      end else if (press[0]) begin
        bus.SELECTOR <= SUB;
      end
    end
  end

  assign bus.BTN_DB = db;

endmodule

// File: tb/tb_btn_debounce_selector.sv
// Bench for btn_debounce_selector with an 8-cycle debounce window.
// Expected selections are queued with the cycle they must appear on and
// matched against every SEL_STROBE pulse; SELECTOR is also checked for
// stickiness on every cycle.

module tb_btn_debounce_selector;
  import types_pkg::*;

  localparam int DB = 8;
  // Drive at cycle c0 -> strobe visible at the negedge where cyc == c0 + DB + 3
  localparam int LAT_SEL = DB + 3;
  localparam int LAT_DB  = DB + 2;

  typedef struct {
    int        cyc;
    opr_mode_t mode;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  bit   mon_en;
  opr_mode_t exp_sel;
  exp_t exp_q[$];

  btn_debounce_selector_if bus ();

  btn_debounce_selector #(.DB_CYCLES(DB)) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: match strobes against queued expectations
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus.SEL_STROBE) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_strobe cyc=%0d selector=%0d", cyc, int'(bus.SELECTOR));
        end else begin
          e = exp_q.pop_front();
          if (cyc !== e.cyc || bus.SELECTOR !== e.mode) begin
            failures++;
            $display("FAIL strobe cyc=%0d selector=%0d required cyc=%0d selector=%0d",
                     cyc, int'(bus.SELECTOR), e.cyc, int'(e.mode));
          end else begin
            $display("strobe ok cyc=%0d selector=%0d", cyc, int'(bus.SELECTOR));
          end
          exp_sel = e.mode;
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        e = exp_q.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_strobe cyc=%0d required cyc=%0d selector=%0d",
                 cyc, e.cyc, int'(e.mode));
        exp_sel = e.mode;
      end
      checks++;
      if (bus.SELECTOR !== exp_sel) begin
        failures++;
        $display("FAIL sticky_selector cyc=%0d selector=%0d required=%0d",
                 cyc, int'(bus.SELECTOR), int'(exp_sel));
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic release_all();
    bus.BTNC = 1'b0;
    bus.BTNU = 1'b0;
    bus.BTND = 1'b0;
    bus.BTNL = 1'b0;
    bus.BTNR = 1'b0;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    exp_sel = RESET;
    release_all();
    wait_cycles(3);
    checks++;
    if (bus.SELECTOR !== RESET || bus.SEL_STROBE !== 1'b0 || bus.BTN_DB !== 5'b0) begin
      failures++;
      $display("FAIL reset_values selector=%0d strobe=%0b btn_db=%b required 0 0 00000",
               int'(bus.SELECTOR), bus.SEL_STROBE, bus.BTN_DB);
    end
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if (bus.SEL_STROBE !== 1'b0 || bus.BTN_DB !== 5'b0) begin
        failures++;
        $display("FAIL idle cyc=%0d strobe=%0b btn_db=%b required 0 00000",
                 cyc, bus.SEL_STROBE, bus.BTN_DB);
      end
    end
    $display("test_reset done cyc=%0d", cyc);
  endtask

  task automatic test_single_press();
    int c0;
    c0 = cyc;
    bus.BTNC = 1'b1;
    exp_q.push_back('{cyc: c0 + LAT_SEL, mode: MUL});
    wait_cycles(LAT_DB - 1);
    checks++;
    if (bus.BTN_DB !== 5'b00000) begin
      failures++;
      $display("FAIL db_early cyc=%0d btn_db=%b required 00000", cyc, bus.BTN_DB);
    end
    wait_cycles(1);
    checks++;
    if (bus.BTN_DB !== 5'b10000) begin
      failures++;
      $display("FAIL db_rise cyc=%0d btn_db=%b required 10000", cyc, bus.BTN_DB);
    end
    wait_cycles(20);
    bus.BTNC = 1'b0;
    wait_cycles(20);
    checks++;
    if (bus.SELECTOR !== MUL || bus.BTN_DB !== 5'b0) begin
      failures++;
      $display("FAIL after_release selector=%0d btn_db=%b required %0d 00000",
               int'(bus.SELECTOR), bus.BTN_DB, int'(MUL));
    end
    $display("test_single_press done cyc=%0d", cyc);
  endtask

  task automatic test_glitch();
    int c0;
    bus.BTNL = 1'b1;
    wait_cycles(5);
    bus.BTNL = 1'b0;
    wait_cycles(2);
    bus.BTNL = 1'b1;
    wait_cycles(5);
    bus.BTNL = 1'b0;
    wait_cycles(20);
    checks++;
    if (bus.SELECTOR !== MUL || bus.BTN_DB !== 5'b0) begin
      failures++;
      $display("FAIL glitch_rejected selector=%0d btn_db=%b required %0d 00000",
               int'(bus.SELECTOR), bus.BTN_DB, int'(MUL));
    end
    c0 = cyc;
    bus.BTNL = 1'b1;
    exp_q.push_back('{cyc: c0 + LAT_SEL, mode: ADD});
    wait_cycles(20);
    bus.BTNL = 1'b0;
    wait_cycles(20);
    $display("test_glitch done cyc=%0d", cyc);
  endtask

  task automatic test_priority();
    int c0;
    c0 = cyc;
    bus.BTNR = 1'b1;
    bus.BTNU = 1'b1;
    exp_q.push_back('{cyc: c0 + LAT_SEL, mode: LEADING_ONES});
    wait_cycles(20);
    checks++;
    if (bus.BTN_DB !== 5'b01001) begin
      failures++;
      $display("FAIL db_two_held btn_db=%b required 01001", bus.BTN_DB);
    end
    c0 = cyc;
    bus.BTND = 1'b1;
    exp_q.push_back('{cyc: c0 + LAT_SEL, mode: COUNT_ONES});
    wait_cycles(20);
    release_all();
    wait_cycles(20);
    checks++;
    if (bus.SELECTOR !== COUNT_ONES || bus.BTN_DB !== 5'b0) begin
      failures++;
      $display("FAIL last_press_holds selector=%0d btn_db=%b required %0d 00000",
               int'(bus.SELECTOR), bus.BTN_DB, int'(COUNT_ONES));
    end
    $display("test_priority done cyc=%0d", cyc);
  endtask

  task automatic test_reset_mid_window();
    int cr;
    bus.BTNU = 1'b1;
    // Six edges later the counter has reached 4
    wait_cycles(6);
    #2;
    rst_n   = 1'b0;
    exp_sel = RESET;
    #1;
    checks++;
    if (bus.SELECTOR !== RESET || bus.SEL_STROBE !== 1'b0 || bus.BTN_DB !== 5'b0) begin
      failures++;
      $display("FAIL async_reset selector=%0d strobe=%0b btn_db=%b required 0 0 00000",
               int'(bus.SELECTOR), bus.SEL_STROBE, bus.BTN_DB);
    end
    wait_cycles(2);
    rst_n = 1'b1;
    cr = cyc;
    exp_q.push_back('{cyc: cr + LAT_SEL, mode: LEADING_ONES});
    wait_cycles(LAT_DB - 1);
    checks++;
    if (bus.BTN_DB !== 5'b00000) begin
      failures++;
      $display("FAIL db_after_reset_early cyc=%0d btn_db=%b required 00000", cyc, bus.BTN_DB);
    end
    wait_cycles(1);
    checks++;
    if (bus.BTN_DB !== 5'b01000) begin
      failures++;
      $display("FAIL db_after_reset cyc=%0d btn_db=%b required 01000", cyc, bus.BTN_DB);
    end
    wait_cycles(20);
    bus.BTNU = 1'b0;
    wait_cycles(20);
    $display("test_reset_mid_window done cyc=%0d", cyc);
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = cyc;
    bus.BTNC = 1'b1;
    exp_q.push_back('{cyc: c0 + LAT_SEL, mode: MUL});
    wait_cycles(25);
    bus.BTNC = 1'b0;
    wait_cycles(25);
    c0 = cyc;
    bus.BTNC = 1'b1;
    exp_q.push_back('{cyc: c0 + LAT_SEL, mode: MUL});
    wait_cycles(25);
    bus.BTNC = 1'b0;
    wait_cycles(25);
    checks++;
    if (bus.SELECTOR !== MUL || exp_q.size() != 0) begin
      failures++;
      $display("FAIL repress selector=%0d pending=%0d required %0d 0",
               int'(bus.SELECTOR), exp_q.size(), int'(MUL));
    end
    $display("test_back_to_back done cyc=%0d", cyc);
  endtask

  initial begin
    cyc      = 0;
    checks   = 0;
    failures = 0;
    mon_en   = 1'b0;
    exp_sel  = RESET;
    rst_n    = 1'b0;
    release_all();
    test_reset();
    test_single_press();
    test_glitch();
    test_priority();
    test_reset_mid_window();
    test_back_to_back();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required 0", exp_q.size());
    end
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
